controle_multiciclo: RTL and testbench
======================================

# controle_multiciclo

Parametrised multicycle MIPS control unit with configurable memory wait states and precise exceptions, driving the existing datapath (PC, IR, A/B, ALUOut, MDR, EPC, register file). It extends the original R-type/immediate controller with load/store, branch, jump, illegal-instruction and overflow handling. It produces Moore-decoded control lines from the state register, plus a Mealy branch-enable.

## Interface
- MEM_WAIT, 2: memory latency in wait cycles after a read is issued; 0..15, 0 removes the wait states.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OpCode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Overflow  in  1  ALU signed overflow, valid in EXEC states.
- Zero  in  1  ALU zero flag.
- PCWrite, MemCtrl (1=write), IRWrite, A_Control, B_Control, RegControl, ALUOutControl, EPCWrite, MDRWrite  out  1 each  register/memory enables.
- IorD, ALUSrcA, ALUSrcB  out  2 each  mux selects.
- RegDst, PCSource, ALUControl  out  3 each  selects / ALU op.
- DataSrc  out  4  register-file write-data select.
- ExcCause  out  2  00 none, 01 illegal instruction, 10 overflow; registered.
- estado  out  7  current state code.

## Operation
- Encodings:
  - ALUControl: 001 add, 010 sub, 011 and.
  - ALUSrcA: 00 PC, 01 A.
  - ALUSrcB: 00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2.
  - PCSource: 000 ALU, 001 ALUOut, 010 jump target, 011 exception vector.
  - IorD: 00 PC, 01 ALUOut. RegDst: 000 rt, 001 rd. DataSrc: 0000 ALUOut, 0001 MDR.
- Outputs not listed for a state are 0.
- States (estado code), with outputs and next state:
  - FETCH 0: ALUSrcB=01, ALUControl=001 (read at PC). Next FETCH_WAIT, or FETCH_WB if MEM_WAIT=0.
  - FETCH_WAIT 1: same outputs as FETCH; stays MEM_WAIT cycles (internal counter).
  - FETCH_WB 2: IRWrite, PCWrite, ALUSrcB=01, ALUControl=001 (PC<=PC+4).
  - DECODE 3: A_Control, B_Control, ALUOutControl, ALUSrcB=11, ALUControl=001 (ALUOut<=branch target). Dispatch on OpCode:
    - 000000 with funct ADD 100000, SUB 100010, AND 100100 -> EXEC_R.
    - ADDI 001000, ADDIU 001001 -> EXEC_I.
    - LW 100011, SW 101011 -> ADDR.
    - BEQ 000100, BNE 000101 -> BRANCH.
    - J 000010 -> JUMP.
    - Any other opcode, or unknown funct -> EXC with cause 01.
  - EXEC_R 4: ALUSrcA=01, ALUSrcB=00, ALUControl per funct, ALUOutControl. Next WB_R; if Overflow and funct is ADD/SUB -> EXC, cause 10.
  - EXEC_I 5: ALUSrcA=01, ALUSrcB=10, ALUControl=001, ALUOutControl. Next WB_I; if Overflow and ADDI -> EXC, cause 10. ADDIU never traps.
  - WB_R 6: RegControl, RegDst=001. WB_I 7: RegControl, RegDst=000. Both -> FETCH.
  - ADDR 8: as EXEC_I (no trap); LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD 9: IorD=01. MEM_RD_WAIT 10: IorD=01, MEM_WAIT cycles (skipped if 0). MDR_LD 11: MDRWrite, IorD=01. LW_WB 12: RegControl, RegDst=000, DataSrc=0001 -> FETCH.
  - MEM_WR 13: IorD=01, MemCtrl=1 for exactly one cycle -> FETCH.
  - BRANCH 14: ALUSrcA=01, ALUSrcB=00, ALUControl=010, PCSource=001; PCWrite = Zero (BEQ) or !Zero (BNE), combinational -> FETCH.
  - JUMP 15: PCSource=010, PCWrite -> FETCH.
  - EXC 16: ALUSrcA=00, ALUSrcB=01, ALUControl=010, EPCWrite (EPC<=PC-4), PCSource=011, PCWrite -> FETCH.
- ExcCause is loaded on entry to EXC and held until the next EXC or reset.

## Timing
- Reset low: estado=0 and wait counter=0 immediately, regardless of state. ExcCause=00. Outputs equal FETCH values: all 0 except ALUSrcB=01, ALUControl=001. This holds mid-write; MemCtrl drops at once.
- First FETCH cycle is the first rising edge after reset deasserts.
- Instruction latency, FETCH to next FETCH, in cycles (MEM_WAIT=2 in brackets):
  - R-type, ADDI/ADDIU, SW: MEM_WAIT+5 [7].
  - BEQ/BNE, J, illegal instruction: MEM_WAIT+4 [6].
  - LW: 2*MEM_WAIT+7 [11].
  - Overflow trap: MEM_WAIT+5 [7].
- Overflow and Zero are sampled only in EXEC_R/EXEC_I and BRANCH respectively; they are ignored elsewhere.

## Test plan
- MEM_WAIT=2, ADD with funct 100000, Overflow=0 -> estado 0,1,1,2,3,4,6,0. RegControl=1, RegDst=001 only in state 6.
- ADDI, Overflow=1 in EXEC_I -> estado 5 then 16; EPCWrite=PCWrite=1, PCSource=011; ExcCause=10; no RegControl. Repeat with ADDIU -> WB_I, no trap.
- LW, MEM_WAIT=2 -> 11 cycles, 10 appears twice, MDRWrite in 11, DataSrc=0001 in 12. With MEM_WAIT=0 -> 7 cycles, states 1 and 10 absent.
- BEQ with Zero=1 -> PCWrite=1, PCSource=001 in 14. Zero=0 -> PCWrite=0. BNE -> inverse.
- OpCode 111111 -> 3 then 16, ExcCause=01. OpCode 0 with funct 000000 -> same.
- reset driven low during MEM_WR (MemCtrl=1) -> estado=0 and MemCtrl=0 within the same cycle, before the next clk edge.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: Moore-decoded datapath controls, Mealy branch enable,
// configurable memory wait states and precise illegal-instruction/overflow exceptions.
module controle_multiciclo #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       MemCtrl,
    output logic       IRWrite,
    output logic       A_Control,
    output logic       B_Control,
    output logic       RegControl,
    output logic       ALUOutControl,
    output logic       EPCWrite,
    output logic       MDRWrite,
    output logic [1:0] IorD,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] RegDst,
    output logic [2:0] PCSource,
    output logic [2:0] ALUControl,
    output logic [3:0] DataSrc,
    output logic [1:0] ExcCause,
    output logic [6:0] estado
);

    typedef enum logic [6:0] {
        FETCH       = 7'd0,
        FETCH_WAIT  = 7'd1,
        FETCH_WB    = 7'd2,
        DECODE      = 7'd3,
        EXEC_R      = 7'd4,
        EXEC_I      = 7'd5,
        WB_R        = 7'd6,
        WB_I        = 7'd7,
        ADDR        = 7'd8,
        MEM_RD      = 7'd9,
        MEM_RD_WAIT = 7'd10,
        MDR_LD      = 7'd11,
        LW_WB       = 7'd12,
        MEM_WR      = 7'd13,
        BRANCH      = 7'd14,
        JUMP        = 7'd15,
        EXC         = 7'd16
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;

    // Last count value of a wait phase; unused (but kept legal) when MEM_WAIT is 0.
    localparam int unsigned WAIT_LAST_I = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
    localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_LAST_I);

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic [1:0] exc_cause, exc_cause_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            exc_cause <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            exc_cause <= exc_cause_next;
        end
    end

    assign estado   = state;
    assign ExcCause = exc_cause;

    always_comb begin
        PCWrite        = 1'b0;
        MemCtrl        = 1'b0;
        IRWrite        = 1'b0;
        A_Control      = 1'b0;
        B_Control      = 1'b0;
        RegControl     = 1'b0;
        ALUOutControl  = 1'b0;
        EPCWrite       = 1'b0;
        MDRWrite       = 1'b0;
        IorD           = 2'b00;
        ALUSrcA        = 2'b00;
        ALUSrcB        = 2'b00;
        RegDst         = 3'b000;
        PCSource       = 3'b000;
        ALUControl     = 3'b000;
        DataSrc        = 4'b0000;
        state_next     = state;
        wait_cnt_next  = '0;
        exc_cause_next = exc_cause;

        case (state)
            FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 3'b001;
                state_next = (MEM_WAIT == 0) ? FETCH_WB : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                ALUSrcB    = 2'b01;
                ALUControl = 3'b001;
                if (wait_cnt == WAIT_LAST) state_next = FETCH_WB;
                else                       wait_cnt_next = wait_cnt + 4'd1;
            end
            FETCH_WB: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b001;
                state_next = DECODE;
            end
            DECODE: begin
                A_Control     = 1'b1;
                B_Control     = 1'b1;
                ALUOutControl = 1'b1;
                ALUSrcB       = 2'b11;
                ALUControl    = 3'b001;
                case (OpCode)
                    OP_R: begin
                        if (funct inside {F_ADD, F_SUB, F_AND}) begin
                            state_next = EXEC_R;
                        end else begin
                            state_next     = EXC;
                            exc_cause_next = 2'b01;
                        end
                    end
                    OP_ADDI, OP_ADDIU: state_next = EXEC_I;
                    OP_LW, OP_SW:      state_next = ADDR;
                    OP_BEQ, OP_BNE:    state_next = BRANCH;
                    OP_J:              state_next = JUMP;
                    default: begin
                        state_next     = EXC;
                        exc_cause_next = 2'b01;
                    end
                endcase
            end
            EXEC_R: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b00;
                ALUOutControl = 1'b1;
                case (funct)
                    F_SUB:   ALUControl = 3'b010;
                    F_AND:   ALUControl = 3'b011;
                    default: ALUControl = 3'b001;
                endcase
                if (Overflow && (funct inside {F_ADD, F_SUB})) begin
                    state_next     = EXC;
                    exc_cause_next = 2'b10;
                end else begin
                    state_next = WB_R;
                end
            end
            EXEC_I: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b10;
                ALUControl    = 3'b001;
                ALUOutControl = 1'b1;
                if (Overflow && (OpCode == OP_ADDI)) begin
                    state_next     = EXC;
                    exc_cause_next = 2'b10;
                end else begin
                    state_next = WB_I;
                end
            end
            WB_R: begin
                RegControl = 1'b1;
                RegDst     = 3'b001;
                state_next = FETCH;
            end
            WB_I: begin
                RegControl = 1'b1;
                RegDst     = 3'b000;
                state_next = FETCH;
            end
            ADDR: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b10;
                ALUControl    = 3'b001;
                ALUOutControl = 1'b1;
                state_next    = (OpCode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                IorD       = 2'b01;
                state_next = (MEM_WAIT == 0) ? MDR_LD : MEM_RD_WAIT;
            end
            MEM_RD_WAIT: begin
                IorD = 2'b01;
                if (wait_cnt == WAIT_LAST) state_next = MDR_LD;
                else                       wait_cnt_next = wait_cnt + 4'd1;
            end
            MDR_LD: begin
                MDRWrite   = 1'b1;
                IorD       = 2'b01;
                state_next = LW_WB;
            end
            LW_WB: begin
                RegControl = 1'b1;
                RegDst     = 3'b000;
                DataSrc    = 4'b0001;
                state_next = FETCH;
            end
            MEM_WR: begin
                IorD       = 2'b01;
                MemCtrl    = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b00;
                ALUControl = 3'b010;
                PCSource   = 3'b001;
                // Mealy: the PC update follows Zero in the same cycle.
                PCWrite    = (OpCode == OP_BNE) ? !Zero : Zero;
                state_next = FETCH;
            end
            JUMP: begin
                PCSource   = 3'b010;
                PCWrite    = 1'b1;
                state_next = FETCH;
            end
            EXC: begin
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                EPCWrite   = 1'b1;
                PCSource   = 3'b011;
                PCWrite    = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: one instance with MEM_WAIT=2, one with MEM_WAIT=0.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset, reset_0;
    logic [5:0] OpCode, funct;
    logic       Overflow, Zero;

    logic       PCWrite, MemCtrl, IRWrite, A_Control, B_Control, RegControl;
    logic       ALUOutControl, EPCWrite, MDRWrite;
    logic [1:0] IorD, ALUSrcA, ALUSrcB, ExcCause;
    logic [2:0] RegDst, PCSource, ALUControl;
    logic [3:0] DataSrc;
    logic [6:0] estado;

    logic       PCWrite_0, MemCtrl_0, IRWrite_0, A_Control_0, B_Control_0, RegControl_0;
    logic       ALUOutControl_0, EPCWrite_0, MDRWrite_0;
    logic [1:0] IorD_0, ALUSrcA_0, ALUSrcB_0, ExcCause_0;
    logic [2:0] RegDst_0, PCSource_0, ALUControl_0;
    logic [3:0] DataSrc_0;
    logic [6:0] estado_0;

    int check_count = 0;
    int err_count   = 0;
    int sel         = 0;
    int exp_seq[$];

    always #5 clk = ~clk;

    controle_multiciclo #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .funct(funct),
        .Overflow(Overflow), .Zero(Zero),
        .PCWrite(PCWrite), .MemCtrl(MemCtrl), .IRWrite(IRWrite),
        .A_Control(A_Control), .B_Control(B_Control), .RegControl(RegControl),
        .ALUOutControl(ALUOutControl), .EPCWrite(EPCWrite), .MDRWrite(MDRWrite),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
        .PCSource(PCSource), .ALUControl(ALUControl), .DataSrc(DataSrc),
        .ExcCause(ExcCause), .estado(estado)
    );

    controle_multiciclo #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset_0), .OpCode(OpCode), .funct(funct),
        .Overflow(Overflow), .Zero(Zero),
        .PCWrite(PCWrite_0), .MemCtrl(MemCtrl_0), .IRWrite(IRWrite_0),
        .A_Control(A_Control_0), .B_Control(B_Control_0), .RegControl(RegControl_0),
        .ALUOutControl(ALUOutControl_0), .EPCWrite(EPCWrite_0), .MDRWrite(MDRWrite_0),
        .IorD(IorD_0), .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0), .RegDst(RegDst_0),
        .PCSource(PCSource_0), .ALUControl(ALUControl_0), .DataSrc(DataSrc_0),
        .ExcCause(ExcCause_0), .estado(estado_0)
    );

    logic [6:0] o_estado;
    logic       o_regc, o_memc, o_pcw, o_epcw, o_mdrw, o_irw;
    logic [2:0] o_dec, o_regdst, o_pcsrc, o_alu;
    logic [1:0] o_srca, o_srcb, o_iord, o_cause;
    logic [3:0] o_datasrc;

    assign o_estado  = (sel != 0) ? estado_0     : estado;
    assign o_regc    = (sel != 0) ? RegControl_0 : RegControl;
    assign o_memc    = (sel != 0) ? MemCtrl_0    : MemCtrl;
    assign o_pcw     = (sel != 0) ? PCWrite_0    : PCWrite;
    assign o_epcw    = (sel != 0) ? EPCWrite_0   : EPCWrite;
    assign o_mdrw    = (sel != 0) ? MDRWrite_0   : MDRWrite;
    assign o_irw     = (sel != 0) ? IRWrite_0    : IRWrite;
    assign o_dec     = (sel != 0) ? {A_Control_0, B_Control_0, ALUOutControl_0}
                                  : {A_Control, B_Control, ALUOutControl};
    assign o_regdst  = (sel != 0) ? RegDst_0     : RegDst;
    assign o_pcsrc   = (sel != 0) ? PCSource_0   : PCSource;
    assign o_alu     = (sel != 0) ? ALUControl_0 : ALUControl;
    assign o_srca    = (sel != 0) ? ALUSrcA_0    : ALUSrcA;
    assign o_srcb    = (sel != 0) ? ALUSrcB_0    : ALUSrcB;
    assign o_iord    = (sel != 0) ? IorD_0       : IorD;
    assign o_cause   = (sel != 0) ? ExcCause_0   : ExcCause;
    assign o_datasrc = (sel != 0) ? DataSrc_0    : DataSrc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one instruction along exp_seq starting in FETCH, checking state-specific controls.
    task automatic run(input string name, input int exp_pcw, input logic [2:0] exp_alu,
                       input logic [1:0] exp_cause);
        int n;
        n = exp_seq.size();
        for (int i = 0; i < n; i++) begin
            int s;
            int pcw;
            s   = exp_seq[i];
            pcw = (s == 2 || s == 15 || s == 16) ? 1 : ((s == 14) ? exp_pcw : 0);
            check($sformatf("%s estado[%0d]", name, i), o_estado, s);
            check($sformatf("%s RegControl[%0d]", name, i), o_regc, (s == 6 || s == 7 || s == 12));
            check($sformatf("%s MemCtrl[%0d]", name, i), o_memc, (s == 13));
            check($sformatf("%s PCWrite[%0d]", name, i), o_pcw, pcw);
            case (s)
                2:  check({name, " IRWrite"}, o_irw, 1);
                3: begin
                    check({name, " decode enables"}, o_dec, 3'b111);
                    check({name, " decode ALUSrcB"}, o_srcb, 2'b11);
                end
                4: begin
                    check({name, " EXEC_R ALUControl"}, o_alu, exp_alu);
                    check({name, " EXEC_R ALUSrcA"}, o_srca, 2'b01);
                end
                5:  check({name, " EXEC_I ALUSrcB"}, o_srcb, 2'b10);
                6:  check({name, " WB_R RegDst"}, o_regdst, 3'b001);
                7:  check({name, " WB_I RegDst"}, o_regdst, 3'b000);
                9:  check({name, " MEM_RD IorD"}, o_iord, 2'b01);
                11: begin
                    check({name, " MDRWrite"}, o_mdrw, 1);
                    check({name, " MDR_LD IorD"}, o_iord, 2'b01);
                end
                12: check({name, " DataSrc"}, o_datasrc, 4'b0001);
                14: begin
                    check({name, " BRANCH PCSource"}, o_pcsrc, 3'b001);
                    check({name, " BRANCH ALUControl"}, o_alu, 3'b010);
                end
                15: check({name, " JUMP PCSource"}, o_pcsrc, 3'b010);
                16: begin
                    check({name, " EPCWrite"}, o_epcw, 1);
                    check({name, " EXC PCSource"}, o_pcsrc, 3'b011);
                    check({name, " EXC ALUControl"}, o_alu, 3'b010);
                end
                default: ;
            endcase
            if (s != 16) check($sformatf("%s EPCWrite[%0d]", name, i), o_epcw, 0);
            step();
        end
        check({name, " back to FETCH"}, o_estado, 0);
        check({name, " ExcCause"}, o_cause, exp_cause);
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic z);
        OpCode   = op;
        funct    = fn;
        Overflow = ovf;
        Zero     = z;
    endtask

    initial begin
        reset   = 1'b0;
        reset_0 = 1'b0;
        set_in(6'd0, 6'd0, 1'b0, 1'b0);
        repeat (2) step();

        check("reset estado", estado, 0);
        check("reset enables", {PCWrite, MemCtrl, IRWrite, A_Control, B_Control, RegControl,
                                ALUOutControl, EPCWrite, MDRWrite}, 0);
        check("reset selects", {IorD, ALUSrcA, RegDst, PCSource, DataSrc, ExcCause}, 0);
        check("reset ALUSrcB", ALUSrcB, 2'b01);
        check("reset ALUControl", ALUControl, 3'b001);
        check("reset0 enables", {PCWrite_0, MemCtrl_0, IRWrite_0, A_Control_0, B_Control_0,
                                 RegControl_0, ALUOutControl_0, EPCWrite_0, MDRWrite_0}, 0);
        check("reset0 selects", {IorD_0, ALUSrcA_0, RegDst_0, PCSource_0, DataSrc_0,
                                 ExcCause_0, estado_0}, 0);
        check("reset0 fetch", {ALUSrcB_0, ALUControl_0}, {2'b01, 3'b001});

        reset = 1'b1;

        set_in(6'b000000, 6'b100000, 1'b0, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 4, 6};
        run("ADD", 0, 3'b001, 2'b00);

        set_in(6'b000000, 6'b100010, 1'b1, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 4, 16};
        run("SUB ovf", 0, 3'b010, 2'b10);

        set_in(6'b111111, 6'b000000, 1'b0, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 16};
        run("ILLEGAL op", 0, 3'b000, 2'b01);

        set_in(6'b001000, 6'b000000, 1'b1, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 5, 16};
        run("ADDI ovf", 0, 3'b000, 2'b10);

        set_in(6'b001001, 6'b000000, 1'b1, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 5, 7};
        run("ADDIU ovf", 0, 3'b000, 2'b10);

        set_in(6'b000000, 6'b100100, 1'b1, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 4, 6};
        run("AND ovf", 0, 3'b011, 2'b10);

        set_in(6'b000000, 6'b000000, 1'b0, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 16};
        run("ILLEGAL funct", 0, 3'b000, 2'b01);

        set_in(6'b100011, 6'b000000, 1'b1, 1'b1);
        exp_seq = '{0, 1, 1, 2, 3, 8, 9, 10, 10, 11, 12};
        run("LW", 0, 3'b000, 2'b01);

        set_in(6'b101011, 6'b000000, 1'b0, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 8, 13};
        run("SW", 0, 3'b000, 2'b01);

        set_in(6'b000100, 6'b000000, 1'b0, 1'b1);
        exp_seq = '{0, 1, 1, 2, 3, 14};
        run("BEQ taken", 1, 3'b000, 2'b01);

        set_in(6'b000100, 6'b000000, 1'b0, 1'b0);
        run("BEQ not taken", 0, 3'b000, 2'b01);

        set_in(6'b000101, 6'b000000, 1'b0, 1'b0);
        run("BNE taken", 1, 3'b000, 2'b01);

        set_in(6'b000101, 6'b000000, 1'b0, 1'b1);
        run("BNE not taken", 0, 3'b000, 2'b01);

        set_in(6'b000010, 6'b000000, 1'b1, 1'b0);
        exp_seq = '{0, 1, 1, 2, 3, 15};
        run("J", 0, 3'b000, 2'b01);

        // Asynchronous reset while a store is writing memory.
        set_in(6'b101011, 6'b000000, 1'b0, 1'b0);
        repeat (6) step();
        check("pre-reset estado", estado, 13);
        check("pre-reset MemCtrl", MemCtrl, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset estado", estado, 0);
        check("async reset MemCtrl", MemCtrl, 0);
        check("async reset ExcCause", ExcCause, 0);
        check("async reset ALUSrcB", ALUSrcB, 2'b01);
        check("async reset IorD", IorD, 2'b00);

        // MEM_WAIT=0 instance: wait states vanish.
        step();
        sel     = 1;
        reset_0 = 1'b1;
        set_in(6'b100011, 6'b000000, 1'b0, 1'b0);
        exp_seq = '{0, 2, 3, 8, 9, 11, 12};
        run("LW nowait", 0, 3'b000, 2'b00);

        set_in(6'b000000, 6'b100000, 1'b0, 1'b0);
        exp_seq = '{0, 2, 3, 4, 6};
        run("ADD nowait", 0, 3'b001, 2'b00);

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule
